fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the ALU in the multi-cycle CPU. It holds the program counter, fetches one 32-bit instruction word per instruction cycle over a req/ack instruction-memory handshake, and presents the instruction and its PC to the ALU. Fetches launch only in the fetch phase of the 4-phase timing vector from the clock generator. The ALU's fetch-enable and redirect outputs select the next PC.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 13 +
 rtl/fetch_wdog.sv | 30 +++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, phase vector, datapath width
// and the opcode field position used by both fetch and ALU.
package cpu_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [3:0] PHASE_FETCH = 4'b0001;

   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 26;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_IDLE = 2'd1,
      ST_REQ  = 2'd2,
      ST_ERR  = 2'd3
   } fetch_state_e;

   function automatic logic [OPC_MSB-OPC_LSB:0] ir_opcode(input logic [XLEN-1:0] ir);
      return ir[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read handshake between the fetch stage and imem.
interface fetch_unit_if;
   import cpu_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_data;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);

endinterface

// File: rtl/fetch_wdog.sv
// Request watchdog: down-counter loaded on clear, expired when an enabled
// cycle finds it at terminal count (the MEM_TIMEOUT-th waiting cycle).
module fetch_wdog #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] TC_LOAD = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= TC_LOAD;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: holds the PC, reads one instruction per cycle over imem
// and presents ir/pc to the ALU.
//
//   state | meaning
//   BOOT  | out of reset, waiting for phase 0 to fetch PC_RESET
//   IDLE  | instruction held for ALU, waiting for ife in phase 0
//   REQ   | imem_req high, waiting for ack or timeout
//   ERR   | memory timed out; frozen until reset
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] PC_RESET    = 32'h0000_0000,
   parameter logic [XLEN-1:0] PC_STEP     = 32'd1,
   parameter int unsigned     MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          t,
   input  logic                ife,
   input  logic                jmp,
   input  logic [XLEN-1:0]     jmp_addr,
   fetch_unit_if.master        imem,
   output logic [XLEN-1:0]     ir_o,
   output logic [XLEN-1:0]     pc_o,
   output logic                valid_o,
   output logic                err_o
);

   fetch_state_e    state_q, state_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] ir_q, ir_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic            fetch_ph;
   logic            wd_expired;

   assign fetch_ph = (t == PHASE_FETCH);

   fetch_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (state_q != ST_REQ),
      .en_i      ((state_q == ST_REQ) && !imem.imem_ack),
      .expired_o (wd_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_BOOT;
         req_q   <= 1'b0;
         addr_q  <= '0;
         ir_q    <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      err_d   = err_q;
      unique case (state_q)
         ST_BOOT: begin
            if (fetch_ph) begin
               addr_d  = PC_RESET;
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_IDLE: begin
            if (fetch_ph && ife) begin
               addr_d  = jmp ? jmp_addr : pc_q + PC_STEP;
               valid_d = 1'b0;
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (imem.imem_ack) begin
               ir_d    = imem.imem_data;
               pc_d    = addr_q;
               valid_d = 1'b1;
               req_d   = 1'b0;
               state_d = ST_IDLE;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               req_d   = 1'b0;
               state_d = ST_ERR;
            end
         end
         ST_ERR: begin
         end
         default: state_d = ST_BOOT;
      endcase
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign ir_o           = ir_q;
   assign pc_o           = pc_q;
   assign valid_o        = valid_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, sequential, redirect, wrap,
// late ack, async reset mid-request and timeout.
module tb_fetch_unit;
   import cpu_pkg::*;

   logic        clk;
   logic        rst;
   logic [3:0]  t;
   logic        ife;
   logic        jmp;
   logic [31:0] jmp_addr;
   logic [31:0] ir_o, pc_o;
   logic        valid_o, err_o;

   int total = 0;
   int bad   = 0;

   fetch_unit_if imem ();

   fetch_unit #(
      .PC_RESET    (32'h0000_0000),
      .PC_STEP     (32'd1),
      .MEM_TIMEOUT (15)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .t        (t),
      .ife      (ife),
      .jmp      (jmp),
      .jmp_addr (jmp_addr),
      .imem     (imem),
      .ir_o     (ir_o),
      .pc_o     (pc_o),
      .valid_o  (valid_o),
      .err_o    (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // launch a fetch in phase 0, ack it in REQ cycle ack_cyc
   task automatic fetch(input logic j, input logic [31:0] ja, input logic [31:0] exp_addr,
                        input int ack_cyc, input logic [31:0] data);
      t = 4'b0001; ife = 1'b1; jmp = j; jmp_addr = ja;
      step();
      t = 4'b0010; ife = 1'b0; jmp = 1'b0;
      chk("launch_req", 32'(imem.imem_req), 32'd1);
      chk("launch_addr", imem.imem_addr, exp_addr);
      chk("launch_valid", 32'(valid_o), 32'd0);
      for (int i = 1; i < ack_cyc; i++) begin
         step();
         chk("wait_req", 32'(imem.imem_req), 32'd1);
         chk("wait_addr", imem.imem_addr, exp_addr);
      end
      imem.imem_ack = 1'b1; imem.imem_data = data;
      step();
      imem.imem_ack = 1'b0; imem.imem_data = 32'hDEAD_BEEF;
      chk("ack_ir", ir_o, data);
      chk("ack_pc", pc_o, exp_addr);
      chk("ack_valid", 32'(valid_o), 32'd1);
      chk("ack_req", 32'(imem.imem_req), 32'd0);
      chk("ack_err", 32'(err_o), 32'd0);
   endtask

   initial begin
      int n;
      rst = 1'b0; t = 4'b0000; ife = 1'b0; jmp = 1'b0; jmp_addr = '0;
      imem.imem_ack = 1'b0; imem.imem_data = '0;
      step(); step();
      chk("rst_req", 32'(imem.imem_req), 32'd0);
      chk("rst_addr", imem.imem_addr, 32'd0);
      chk("rst_ir", ir_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);

      // boot: non-fetch phase first, then phase 0
      rst = 1'b1; t = 4'b0100;
      step();
      chk("boot_wait_req", 32'(imem.imem_req), 32'd0);
      t = 4'b0001;
      step();
      t = 4'b0010;
      chk("boot_req", 32'(imem.imem_req), 32'd1);
      chk("boot_addr", imem.imem_addr, 32'd0);
      imem.imem_ack = 1'b1; imem.imem_data = 32'h8400_0004;
      step();
      imem.imem_ack = 1'b0;
      chk("boot_ir", ir_o, 32'h8400_0004);
      chk("boot_pc", pc_o, 32'd0);
      chk("boot_valid", 32'(valid_o), 32'd1);
      t = 4'b0001;
      step(); step();
      chk("boot_noife_req", 32'(imem.imem_req), 32'd0);

      fetch(1'b0, '0, 32'd1, 1, 32'h1111_0001);
      fetch(1'b0, '0, 32'd2, 2, 32'h2222_0002);

      // ife outside phase 0, multi-hot, all-zero: no launch
      t = 4'b0100; ife = 1'b1;
      step();
      chk("ife_t4_req", 32'(imem.imem_req), 32'd0);
      t = 4'b0011;
      step();
      chk("ife_multihot_req", 32'(imem.imem_req), 32'd0);
      t = 4'b0000;
      step();
      chk("ife_t0_req", 32'(imem.imem_req), 32'd0);
      chk("ife_hold_valid", 32'(valid_o), 32'd1);
      ife = 1'b0;
      // stray ack and jmp without ife are ignored
      t = 4'b0001; jmp = 1'b1; jmp_addr = 32'h0000_0080;
      imem.imem_ack = 1'b1; imem.imem_data = 32'h5555_5555;
      step();
      imem.imem_ack = 1'b0; jmp = 1'b0;
      chk("jmp_noife_req", 32'(imem.imem_req), 32'd0);
      chk("stray_ack_ir", ir_o, 32'h2222_0002);

      fetch(1'b0, '0, 32'd3, 3, 32'h3333_0003);
      fetch(1'b1, 32'h0000_0040, 32'h0000_0040, 1, 32'h4040_4040);
      fetch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_0000);
      fetch(1'b0, '0, 32'h0000_0000, 2, 32'h0000_AAAA);
      fetch(1'b0, '0, 32'h0000_0001, 15, 32'h0F0F_0F0F);

      // async reset in REQ cycle 2
      t = 4'b0001; ife = 1'b1;
      step();
      t = 4'b0010; ife = 1'b0;
      step();
      chk("mid_req_before", 32'(imem.imem_req), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_req", 32'(imem.imem_req), 32'd0);
      chk("mid_rst_addr", imem.imem_addr, 32'd0);
      chk("mid_rst_ir", ir_o, 32'd0);
      chk("mid_rst_pc", pc_o, 32'd0);
      chk("mid_rst_valid", 32'(valid_o), 32'd0);
      step();
      rst = 1'b1; t = 4'b0001;
      step();
      t = 4'b0010;
      chk("reboot_req", 32'(imem.imem_req), 32'd1);
      chk("reboot_addr", imem.imem_addr, 32'd0);
      imem.imem_ack = 1'b1; imem.imem_data = 32'h8400_0004;
      step();
      imem.imem_ack = 1'b0;
      chk("reboot_ir", ir_o, 32'h8400_0004);
      chk("reboot_valid", 32'(valid_o), 32'd1);

      // timeout: count cycles with req high
      t = 4'b0001; ife = 1'b1;
      step();
      t = 4'b0010; ife = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (imem.imem_req !== 1'b1) break;
         n++;
         step();
      end
      chk("to_req_cycles", 32'(n), 32'd15);
      chk("to_err", 32'(err_o), 32'd1);
      chk("to_req_low", 32'(imem.imem_req), 32'd0);
      t = 4'b0001; ife = 1'b1; imem.imem_ack = 1'b1; imem.imem_data = 32'h7777_7777;
      step(); step(); step();
      ife = 1'b0; imem.imem_ack = 1'b0;
      chk("err_sticky", 32'(err_o), 32'd1);
      chk("err_no_req", 32'(imem.imem_req), 32'd0);
      chk("err_no_valid", 32'(valid_o), 32'd0);
      chk("err_ir_hold", ir_o, 32'h8400_0004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
